// File: rtl/beam_sort_pkg.sv
// Shared types for the beam top-K sorter: slot record, FSM encoding and the
// all-ones index used to mark empty slots in the packed output word.
package beam_sort_pkg;

    localparam int BS_NUM_BEAMS = 64;
    localparam int BS_POW_WIDTH = 32;
    localparam int BS_IDX_WIDTH = $clog2(BS_NUM_BEAMS);

    localparam logic [BS_IDX_WIDTH-1:0] INVALID_IDX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    typedef struct packed {
        logic                    vld;
        logic [BS_POW_WIDTH-1:0] pow;
        logic [BS_IDX_WIDTH-1:0] idx;
    } slot_t;

endpackage

// File: rtl/beam_sort_slot_cmp.sv
// Per-slot "insert here" decision for the streaming top-K list.
module beam_sort_slot_cmp
    import beam_sort_pkg::*;
(
    input  logic                    i_slot_vld,
    input  logic [BS_POW_WIDTH-1:0] i_slot_pow,
    input  logic [BS_POW_WIDTH-1:0] i_smp_pow,
    output logic                    o_ins
);

    // Strictly greater: an equal-power sample lands behind the earlier beam.
    assign o_ins = !i_slot_vld || (i_smp_pow > i_slot_pow);

endmodule

// File: rtl/beam_topk_sort.sv
// Streaming top-K beam selector: keeps a sorted list of the strongest beams per
// symbol and emits the packed index word two cycles after eop.
// Optional BEAM_SORT_POW_OUT_EN adds o_pow_data with the matching sorted powers.
module beam_topk_sort
    import beam_sort_pkg::*;
#(
    parameter int NUM_BEAMS = BS_NUM_BEAMS,
    parameter int POW_WIDTH = BS_POW_WIDTH,
    parameter int TOPK      = 16,
    parameter int IDX_WIDTH = $clog2(NUM_BEAMS)
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [POW_WIDTH-1:0]      i_pow_data,
    input  logic                      i_pow_vld,
    input  logic                      i_pow_sop,
    input  logic                      i_pow_eop,
    output logic [TOPK*IDX_WIDTH-1:0] o_idx_data,
`ifdef BEAM_SORT_POW_OUT_EN
    output logic [TOPK*POW_WIDTH-1:0] o_pow_data,
`endif
    output logic                      o_idx_wen,
    output logic                      o_busy,
    output logic                      o_err_len
);

    localparam logic [IDX_WIDTH:0] NB = (IDX_WIDTH+1)'(NUM_BEAMS);

    state_e               state, state_nxt;
    logic [IDX_WIDTH:0]   cnt;
    logic [IDX_WIDTH:0]   len_nxt;
    logic [IDX_WIDTH-1:0] smp_idx;
    logic                 start, cont, ins_en, eop_acc;
    logic                 abort_err, ovf_err, len_bad, len_bad_q, flush;

    slot_t [TOPK-1:0]                 slots, slots_eff, slots_nxt;
    logic  [TOPK-1:0]                 ins;
    logic  [TOPK-1:0][IDX_WIDTH-1:0]  idx_pack;
    slot_t                            smp;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (eop_acc)                 state_nxt = ST_FLUSH;
        else if (start)              state_nxt = ST_COLLECT;
        else if (state == ST_FLUSH)  state_nxt = ST_IDLE;
    end

    // Sop is honoured in every state; a sop inside COLLECT aborts the symbol.
    always_comb begin
        start     = i_pow_vld && i_pow_sop;
        cont      = i_pow_vld && !i_pow_sop && (state == ST_COLLECT) && (cnt != NB);
        ins_en    = start || cont;
        eop_acc   = i_pow_vld && i_pow_eop && (start || (state == ST_COLLECT));
        abort_err = start && (state == ST_COLLECT);
        smp_idx   = start ? '0 : cnt[IDX_WIDTH-1:0];
        len_nxt   = start ? (IDX_WIDTH+1)'(1) : cnt + 1'b1;
        len_bad   = eop_acc && (len_nxt != NB);
        ovf_err   = ins_en && !i_pow_eop && (len_nxt == NB);
        flush     = (state == ST_FLUSH);
        o_busy    = (state != ST_IDLE);
    end

    assign smp = '{vld: 1'b1, pow: i_pow_data, idx: smp_idx};

    // The list is kept sorted, so ins[] is a thermometer: the first set bit is
    // the insertion point and every later slot takes its predecessor.
    for (genvar g = 0; g < TOPK; g++) begin : g_slot
        assign slots_eff[g] = start ? '0 : slots[g];

        beam_sort_slot_cmp u_cmp (
            .i_slot_vld (slots_eff[g].vld),
            .i_slot_pow (slots_eff[g].pow),
            .i_smp_pow  (smp.pow),
            .o_ins      (ins[g])
        );

        if (g == 0) begin : g_head
            assign slots_nxt[g] = ins[g] ? smp : slots_eff[g];
        end else begin : g_body
            assign slots_nxt[g] = !ins[g]    ? slots_eff[g]   :
                                  ins[g-1]   ? slots_eff[g-1] : smp;
        end

        assign idx_pack[g] = slots[g].vld ? slots[g].idx : INVALID_IDX;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt   <= '0;
            slots <= '0;
        end else if (ins_en) begin
            cnt   <= len_nxt;
            slots <= slots_nxt;
        end
    end

    // Output word is captured from the settled list during FLUSH, so a new
    // sop in that same cycle cannot disturb it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_idx_data <= '0;
            o_idx_wen  <= 1'b0;
            o_err_len  <= 1'b0;
            len_bad_q  <= 1'b0;
        end else begin
            o_idx_wen <= flush;
            len_bad_q <= len_bad;
            o_err_len <= abort_err || ovf_err || len_bad_q;
            if (flush) o_idx_data <= idx_pack;
        end
    end

`ifdef BEAM_SORT_POW_OUT_EN
    logic [TOPK-1:0][POW_WIDTH-1:0] pow_pack;

    for (genvar g = 0; g < TOPK; g++) begin : g_pow
        assign pow_pack[g] = slots[g].vld ? slots[g].pow : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)  o_pow_data <= '0;
        else if (flush)  o_pow_data <= pow_pack;
    end
`endif

endmodule
